// File: rtl/philv_pkg.sv
// philv_pkg: shared types and helpers for the philosophyVCore fetch front-end.
//   XLEN          - datapath / PC width
//   NOP_INSTR     - canonical no-op encoding (addi x0,x0,0)
//   fetch_entry_t - {instr, pc} pair carried through the prefetch queue
//   imem_word_addr() - byte PC -> instruction-memory word address
package philv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Word address of a byte PC; callers keep as many low bits as their memory has.
  function automatic logic [XLEN-3:0] imem_word_addr(input logic [XLEN-1:0] pc);
    return pc[XLEN-1:2];
  endfunction

endpackage

// File: rtl/philv_prefetch_fifo.sv
// philv_prefetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t.
//   clk, rstb : clock, async active-low reset (clears storage, so head reads 0)
//   push, din : write din at the tail
//   pop       : drop the head (ignored when empty)
//   flush     : empty the queue; wins over push/pop in the same cycle
//   count     : current occupancy, 0..DEPTH
//   head      : oldest entry (stale value when count==0)
module philv_prefetch_fifo
  import philv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // The issue logic reserves a slot for every read it launches, so a push
  // into a full queue without a matching pop means that accounting broke.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstb)
    (push && !do_pop && !flush) |-> (count != CW'(DEPTH)));

endmodule

// File: rtl/philv_fetch_unit.sv
// philv_fetch_unit: instruction fetch front-end for philosophyVCore.
// Owns the fetch PC, reads a 1-cycle-latency instruction memory, queues the
// returned words with their PCs and hands {instr, pc} to the controller.
//   clk, rstb            : clock, async active-low reset
//   imem_rd_en/imem_addr : word read request (addr = fetch_pc[IMEM_ADDR_W+1:2])
//   imem_rd_data         : read data, valid the cycle after imem_rd_en
//   instr_valid/ready    : head-of-queue handshake; transfer pops the head
//   instr, instr_pc      : head instruction and its PC
//   redirect/redirect_pc : one-cycle flush-and-refetch request
//   misaligned           : one-cycle pulse after a redirect with pc[1:0]!=0
// XLEN must match philv_pkg::XLEN since queue entries use the package type.
module philv_fetch_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              IMEM_ADDR_W = 8,
  parameter int              DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rstb,
  output logic                   imem_rd_en,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rd_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [31:0]            instr,
  output logic [XLEN-1:0]        instr_pc,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   misaligned
);
  import philv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc, req_pc;
  logic            inflight, squash;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic            pop, push, issue;
  fetch_entry_t    din, head;
  logic [XLEN-3:0] waddr;
  logic            unused_waddr;

  assign pop = instr_valid && instr_ready;

  // Slots committed after this edge: queued + the read landing now - the pop.
  // Issuing only while that is below DEPTH keeps a free slot for every read.
  assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  // rstb gates the strobe so it is low throughout reset, while the state
  // that would otherwise enable it is already cleared.
  assign issue = rstb && !redirect && (occ < (CW+1)'(DEPTH));

  assign waddr        = imem_word_addr(fetch_pc);
  assign imem_addr    = waddr[IMEM_ADDR_W-1:0];
  assign unused_waddr = ^waddr[XLEN-3:IMEM_ADDR_W];
  assign imem_rd_en   = issue;

  assign push      = inflight && !squash;
  assign din.instr = imem_rd_data;
  assign din.pc    = req_pc;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      fetch_pc   <= RESET_PC;
      req_pc     <= '0;
      inflight   <= 1'b0;
      squash     <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= redirect && (redirect_pc[1:0] != 2'b00);
      if (redirect) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        // A response landing in the redirect cycle is dropped by the flush;
        // squash also covers the following cycle so nothing fetched before
        // the redirect can reach the queue.
        squash   <= inflight;
        inflight <= 1'b0;
      end else begin
        squash   <= 1'b0;
        inflight <= issue;
        if (issue) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + XLEN'(4);
        end
      end
    end
  end

  philv_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .count (count),
    .head  (head)
  );

  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_philv_fetch_unit.sv
// Bench for philv_fetch_unit: directed latency/boundary checks plus a random
// phase; a scoreboard of expected {instr, pc} is checked on every transfer.
module tb_philv_fetch_unit;

  localparam int          AW    = 8;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rd_data = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b1;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          misaligned;

  always #5 clk = ~clk;

  philv_fetch_unit #(.XLEN(32), .RESET_PC(RPC), .IMEM_ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstb(rstb), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_rd_data(imem_rd_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .redirect(redirect), .redirect_pc(redirect_pc),
    .misaligned(misaligned)
  );

  // Instruction memory: synchronous, 1-cycle read, address wraps on AW bits.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (imem_rd_en) imem_rd_data <= mem[imem_addr];

  // Reference model: the instruction stream is simply consecutive words from
  // the last restart PC (reset or redirect), with 32-bit PC wrap.
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } exp_t;
  exp_t        sbq[$];
  exp_t        e;
  logic [31:0] mpc;
  int          nchk = 0, nerr = 0, nxfer = 0;
  logic        prev_red = 1'b0, prev_mis = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic sb_top();
    exp_t t;
    while (sbq.size() < 8) begin
      t.pc    = mpc;
      t.instr = mem[mpc[AW+1:2]];
      sbq.push_back(t);
      mpc += 32'd4;
    end
  endtask

  task automatic sb_reset(input logic [31:0] pc);
    sbq.delete();
    mpc = {pc[31:2], 2'b00};
    sb_top();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sb_top();
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Monitor: every transfer must match the scoreboard head; misaligned must
  // pulse exactly in the cycle after a misaligned redirect.
  initial begin
    forever begin
      @(negedge clk);
      if (rstb) begin
        chk("misaligned", {31'b0, misaligned}, {31'b0, prev_red && prev_mis});
        // A pop in a redirect cycle is discarded by the controller.
        if (instr_valid && instr_ready && !redirect) begin
          if (sbq.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL xfer_unexpected: got pc %h, expected no transfer", instr_pc);
          end else begin
            e = sbq.pop_front();
            chk("xfer_pc", instr_pc, e.pc);
            chk("xfer_instr", instr, e.instr);
            nxfer++;
          end
        end
        prev_red = redirect;
        prev_mis = |redirect_pc[1:0];
      end else begin
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_rd_en", {31'b0, imem_rd_en}, 32'd0);
        prev_red = 1'b0;
      end
    end
  end

  int rst_hold = 0;

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h1000_0000 + i;
    mpc = RPC;

    // Reset state
    tick(); tick();
    chk("reset_valid", {31'b0, instr_valid}, 32'd0);
    chk("reset_rd_en", {31'b0, imem_rd_en}, 32'd0);
    chk("reset_instr", instr, 32'd0);
    chk("reset_pc", instr_pc, 32'd0);
    chk("reset_mis", {31'b0, misaligned}, 32'd0);

    // 1: release; read at cycle 0, first valid at cycle 2
    tick(); sb_reset(RPC); rstb = 1'b1; instr_ready = 1'b1;
    smp(); chk("c0_rd_en", {31'b0, imem_rd_en}, 32'd1);
           chk("c0_addr", {24'b0, imem_addr}, 32'd0);
           chk("c0_valid", {31'b0, instr_valid}, 32'd0);
    tick(); smp(); chk("c1_valid", {31'b0, instr_valid}, 32'd0);
    tick(); smp(); chk("c2_valid", {31'b0, instr_valid}, 32'd1);
                   chk("c2_instr", instr, 32'h1000_0000);
                   chk("c2_pc", instr_pc, 32'd0);

    // 2: stall for 6 cycles from cycle 3; queue full, no reads issued
    tick(); instr_ready = 1'b0;
    smp(); chk("stall_rd_en", {31'b0, imem_rd_en}, 32'd0);
    for (int k = 4; k <= 8; k++) begin
      tick(); smp();
      chk("stall_rd_en", {31'b0, imem_rd_en}, 32'd0);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_head_pc", instr_pc, 32'd4);
    end
    tick(); instr_ready = 1'b1;
    smp(); chk("release_rd_en", {31'b0, imem_rd_en}, 32'd1);
    repeat (4) tick();

    // 3: redirect to 0x40 with a read in flight
    tick(); redirect = 1'b1; redirect_pc = 32'h40; sb_reset(32'h40);
    smp(); chk("redir_rd_en", {31'b0, imem_rd_en}, 32'd0);
    tick(); redirect = 1'b0;
    smp(); chk("redir1_valid", {31'b0, instr_valid}, 32'd0);
           chk("redir1_rd_en", {31'b0, imem_rd_en}, 32'd1);
           chk("redir1_addr", {24'b0, imem_addr}, 32'h10);
    tick(); smp(); chk("redir2_valid", {31'b0, instr_valid}, 32'd0);
    tick(); smp(); chk("redir3_valid", {31'b0, instr_valid}, 32'd1);
                   chk("redir3_pc", instr_pc, 32'h40);
    repeat (3) tick();

    // 4: misaligned redirect to 0x42
    tick(); redirect = 1'b1; redirect_pc = 32'h42; sb_reset(32'h42);
    smp(); chk("mis_r0", {31'b0, misaligned}, 32'd0);
    tick(); redirect = 1'b0;
    smp(); chk("mis_r1", {31'b0, misaligned}, 32'd1);
    tick(); smp(); chk("mis_r2", {31'b0, misaligned}, 32'd0);
    tick(); smp(); chk("mis_r3_pc", instr_pc, 32'h40);
                   chk("mis_r3_valid", {31'b0, instr_valid}, 32'd1);

    // 5: PC wrap at the top of the address space
    tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; sb_reset(32'hFFFF_FFF8);
    tick(); redirect = 1'b0;
    tick();
    tick(); smp(); chk("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
    tick(); smp(); chk("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
    tick(); smp(); chk("wrap_pc2", instr_pc, 32'h0000_0000);
                   chk("wrap_instr2", instr, 32'h1000_0000);

    // 6: reset mid-stream with a full queue
    instr_ready = 1'b0;
    repeat (4) tick();
    smp(); chk("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
    tick(); rstb = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("midrst_rd_en", {31'b0, imem_rd_en}, 32'd0);
    chk("midrst_pc", instr_pc, 32'd0);
    for (int i = 0; i < (1<<AW); i++) mem[i] = $urandom;
    tick(); tick();
    sb_reset(RPC); rstb = 1'b1; instr_ready = 1'b1;
    smp(); chk("rr_c0_rd_en", {31'b0, imem_rd_en}, 32'd1);
           chk("rr_c0_valid", {31'b0, instr_valid}, 32'd0);
    tick(); smp(); chk("rr_c1_valid", {31'b0, instr_valid}, 32'd0);
    tick(); smp(); chk("rr_c2_valid", {31'b0, instr_valid}, 32'd1);
                   chk("rr_c2_pc", instr_pc, RPC);
                   chk("rr_c2_instr", instr, mem[0]);

    // Random phase: stalls, redirects at arbitrary alignment, occasional resets
    nxfer = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      redirect = 1'b0;
      redirect_pc = $urandom;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) begin
          sb_reset(RPC);
          rstb = 1'b1;
        end
      end else if ($urandom_range(0, 299) == 0) begin
        rstb = 1'b0;
        rst_hold = 2;
      end else if ($urandom_range(0, 29) == 0) begin
        redirect = 1'b1;
        sb_reset(redirect_pc);
      end
      instr_ready = ($urandom_range(0, 3) != 0);
    end
    tick(); redirect = 1'b0; rstb = 1'b1;
    tick();
    chk("random_progress", {31'b0, (nxfer >= 800)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
